cpu_trace_capture: RTL
======================

Name: cpu_trace_capture

Overview:
Synthesisable 6502 bus-trace engine. It samples one record per CPU cycle (address, data, RnW, SYNC), applies a selectable capture filter and buffers records in a parametrised FIFO. Each record is serialised onto a narrow beat-wide output (gpio trace pins) with a valid/ready handshake. It sits beside the CPU in the Atom core, replacing the fixed single-cycle gpio trace mux, and is enabled by the trace button path.

Parameters:
ADDR_W, 16, CPU address width
DATA_W, 8, CPU data width
OUT_W, 10, output beat width in bits (1..32)
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 records
REC_W, ADDR_W+DATA_W+3, record width {ovf, sync, rnw, addr, data}; derived, not overridable
NBEATS, ceil(REC_W/OUT_W), beats per record; derived (27 bits / 10 -> 3 beats)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cpu_clken  in  1  one-cycle pulse marking end of a CPU bus cycle (phi2 falling equivalent)
cpu_addr  in  ADDR_W  CPU address, valid when cpu_clken
cpu_din  in  DATA_W  CPU data bus value (read or write), valid when cpu_clken
cpu_rnw  in  1  1 = read
cpu_sync  in  1  1 = opcode fetch
trace_en  in  1  capture enable (level)
mode  in  2  0 all cycles, 1 SYNC only, 2 address window, 3 writes only
win_lo  in  ADDR_W  window low bound, inclusive
win_hi  in  ADDR_W  window high bound, inclusive
out_data  out  OUT_W  current beat
out_first  out  1  high on beat 0 of a record
out_valid  out  1  beat valid
out_ready  in  1  consumer accepts beat when valid&ready
fifo_level  out  DEPTH_LOG2+1  records held, including one in serialiser
overflow  out  1  sticky: a record was dropped since reset/trace_en rise

Behaviour:
- Reset: FIFO empty, serialiser IDLE, out_data=0, out_first=0, out_valid=0, fifo_level=0, overflow=0, pending_ovf=0. Reset mid-record abandons the record; no partial beats after release.
- Capture qualifier q = trace_en & cpu_clken & filter; filter per mode: 0 true; 1 cpu_sync; 2 win_lo<=cpu_addr<=win_hi (unsigned; win_lo>win_hi matches nothing); 3 !cpu_rnw.
- On q: if FIFO not full, write {pending_ovf, sync, rnw, addr, data}, clear pending_ovf. If full, drop, set pending_ovf and overflow.
- Simultaneous write and pop when full: pop frees space the same cycle only if the serialiser pops this cycle; write accepted (no drop).
- trace_en rising edge clears overflow and pending_ovf; FIFO contents preserved. trace_en low stops capture only; draining continues.
- Serialiser FSM: IDLE -> LOAD (pop FIFO into shift register, 1 cycle) -> SEND (beat index 0..NBEATS-1) -> IDLE, or LOAD again if FIFO non-empty when the last beat is accepted. out_valid high throughout SEND.
- Beat k = record bits [k*OUT_W +: OUT_W], LSB first; bits beyond REC_W in the last beat are 0. out_first=1 iff k=0.
- Beat advances only on out_valid & out_ready; out_data/out_first stable while valid & !ready.
- Latency: q at cycle t into empty FIFO with ready=1 -> beat 0 valid at t+2, last beat at t+1+NBEATS.
- fifo_level = FIFO count + (serialiser busy ? 1 : 0); saturates at 2**DEPTH_LOG2 + 1.
- Throughput: one record per NBEATS+1 cycles sustained with ready held high.

Decomposition:
- Shared package trace_pkg: mode encodings (TR_ALL, TR_SYNC, TR_WIN, TR_WR), record field offsets, function for ceil division used for NBEATS.
- One sub-module: trace_fifo (synchronous FIFO, parametrised width/depth, full/empty/count, asynchronous active-low reset). Filter and serialiser FSM stay in cpu_trace_capture.

Test Plan:
- Mode 0, ready=1, cycle addr=0xFFFC data=0x3F rnw=1 sync=0 -> 3 beats 0x03F, 0x3FF (addr bits 9:0 << 8 merge), upper beat per bit map; out_first only on beat 0; record reconstructs exactly.
- Mode 1, 8 cycles with sync on cycles 0 and 5 -> exactly 2 records out, both sync=1.
- Mode 2, win 0xB000..0xB003, addresses 0xAFFF, 0xB000, 0xB003, 0xB004 -> only 0xB000 and 0xB003 emitted.
- DEPTH_LOG2=2, ready=0, 7 qualified cycles -> fifo_level=5, overflow=1, 2 dropped; release ready -> 5 records, next captured record has ovf bit=1, later ones ovf=0.
- Ready toggled randomly every cycle -> out_data stable while stalled, no beat lost or duplicated against scoreboard.
- Assert reset_n low during beat 1 -> all outputs 0 asynchronously; after release no residual beats, fresh capture starts at beat 0.

Source files
------------

// File: rtl/trace_pkg.sv
// ============================================================================
// trace_pkg : mode encodings, record field offsets, ceil-division helper
// Rev 1.0
// ============================================================================
`default_nettype none

package trace_pkg;

  typedef enum logic [1:0] {
    TR_ALL  = 2'd0,
    TR_SYNC = 2'd1,
    TR_WIN  = 2'd2,
    TR_WR   = 2'd3
  } trace_mode_e;

  // Record layout, LSB first: data, addr, rnw, sync, ovf
  localparam int REC_DATA_LSB = 0;

  function automatic int rec_addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int rec_rnw_bit(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int rec_sync_bit(input int addr_w, input int data_w);
    return addr_w + data_w + 1;
  endfunction

  function automatic int rec_ovf_bit(input int addr_w, input int data_w);
    return addr_w + data_w + 2;
  endfunction

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trace_fifo.sv
// ============================================================================
// trace_fifo : synchronous record FIFO with full/empty/count
// Rev 1.0
// ============================================================================
`default_nettype none

module trace_fifo #(
  parameter int WIDTH      = 27,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_rd,
  output logic [WIDTH-1:0]      o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_wr;
  logic                  w_do_rd;

  assign o_full  = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // A read in the same cycle frees the slot, so a write to a full FIFO is legal then
  assign w_do_rd = i_rd & ~o_empty;
  assign w_do_wr = i_wr & (~o_full | w_do_rd);

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_trace_capture.sv
// ============================================================================
// cpu_trace_capture : filtered 6502 bus-cycle capture, FIFO, beat serialiser
// Rev 1.0
// ============================================================================
`default_nettype none

module cpu_trace_capture
  import trace_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int OUT_W      = 10,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cpu_clken,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_din,
  input  logic                  cpu_rnw,
  input  logic                  cpu_sync,
  input  logic                  trace_en,
  input  logic [1:0]            mode,
  input  logic [ADDR_W-1:0]     win_lo,
  input  logic [ADDR_W-1:0]     win_hi,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_first,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow
);

  localparam int REC_W    = ADDR_W + DATA_W + 3;
  localparam int NBEATS   = ceil_div(REC_W, OUT_W);
  localparam int SH_W     = NBEATS * OUT_W;
  localparam int BEAT_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int ADDR_LSB = rec_addr_lsb(DATA_W);
  localparam int RNW_BIT  = rec_rnw_bit(ADDR_W, DATA_W);
  localparam int SYNC_BIT = rec_sync_bit(ADDR_W, DATA_W);
  localparam int OVF_BIT  = rec_ovf_bit(ADDR_W, DATA_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [SH_W-1:0]     r_shift;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_te_d;
  logic                r_pending_ovf;
  logic                r_overflow;

  logic                w_filter;
  logic                w_q;
  logic                w_rise;
  logic                w_pend_eff;
  logic                w_pop;
  logic                w_wr_acc;
  logic                w_drop;
  logic                w_last;
  logic                w_busy;
  logic [REC_W-1:0]    w_rec;
  logic [REC_W-1:0]    w_rdata;
  logic                w_full;
  logic                w_empty;
  logic [DEPTH_LOG2:0] w_count;

  always_comb begin
    w_filter = 1'b0;
    case (trace_mode_e'(mode))
      TR_ALL:  w_filter = 1'b1;
      TR_SYNC: w_filter = cpu_sync;
      TR_WIN:  w_filter = (cpu_addr >= win_lo) && (cpu_addr <= win_hi);
      TR_WR:   w_filter = ~cpu_rnw;
      default: w_filter = 1'b0;
    endcase
  end

  assign w_q        = trace_en & cpu_clken & w_filter;
  assign w_rise     = trace_en & ~r_te_d;
  assign w_pend_eff = r_pending_ovf & ~w_rise;

  // Full only blocks a write when the serialiser is not popping this very cycle
  assign w_wr_acc = w_q & (~w_full | w_pop);
  assign w_drop   = w_q & w_full & ~w_pop;

  always_comb begin
    w_rec                          = '0;
    w_rec[REC_DATA_LSB +: DATA_W]  = cpu_din;
    w_rec[ADDR_LSB +: ADDR_W]      = cpu_addr;
    w_rec[RNW_BIT]                 = cpu_rnw;
    w_rec[SYNC_BIT]                = cpu_sync;
    w_rec[OVF_BIT]                 = w_pend_eff;
  end

  trace_fifo #(
    .WIDTH      (REC_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset_n),
    .i_wr    (w_wr_acc),
    .i_wdata (w_rec),
    .i_rd    (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_te_d        <= 1'b0;
      r_pending_ovf <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_te_d <= trace_en;
      if (w_drop) begin
        r_pending_ovf <= 1'b1;
        r_overflow    <= 1'b1;
      end else begin
        if (w_wr_acc || w_rise) begin
          r_pending_ovf <= 1'b0;
        end
        if (w_rise) begin
          r_overflow <= 1'b0;
        end
      end
    end
  end

  assign w_last = (r_beat == BEAT_W'(NBEATS - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Entering LOAD on an incoming write gives beat 0 two cycles after capture
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty || w_wr_acc) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: w_state_nxt = S_SEND;
      S_SEND: begin
        if (out_ready && w_last) begin
          w_state_nxt = w_empty ? S_IDLE : S_LOAD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop     = (r_state == S_LOAD);
    w_busy    = (r_state == S_SEND);
    out_valid = w_busy;
    out_first = w_busy && (r_beat == '0);
    out_data  = w_busy ? r_shift[OUT_W-1:0] : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_beat  <= '0;
    end else if (w_pop) begin
      r_shift <= SH_W'(w_rdata);
      r_beat  <= '0;
    end else if (w_busy && out_ready) begin
      r_shift <= r_shift >> OUT_W;
      r_beat  <= r_beat + BEAT_W'(1);
    end
  end

  assign fifo_level = w_count + {{DEPTH_LOG2{1'b0}}, w_busy};
  assign overflow   = r_overflow;

endmodule

`default_nettype wire
